// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Brief    : Shared icode constants, fetch FSM states, instruction field
//            offsets and the instruction well-formedness helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [3:0] c_I_HALT  = 4'h0;
    localparam logic [3:0] c_I_NOP   = 4'h1;
    localparam logic [3:0] c_I_RRMOV = 4'h2;
    localparam logic [3:0] c_I_IRMOV = 4'h3;
    localparam logic [3:0] c_I_RMMOV = 4'h4;
    localparam logic [3:0] c_I_MRMOV = 4'h5;
    localparam logic [3:0] c_I_OPQ   = 4'h6;
    localparam logic [3:0] c_I_JXX   = 4'h7;
    localparam logic [3:0] c_I_CALL  = 4'h8;
    localparam logic [3:0] c_I_RET   = 4'h9;
    localparam logic [3:0] c_I_PUSHQ = 4'hA;
    localparam logic [3:0] c_I_POPQ  = 4'hB;

    localparam logic [3:0] c_REG_NONE = 4'hF;

    // Header nibbles sit directly above the valC field; offsets are relative to VALC_W.
    localparam int c_FIXED_W   = 16;
    localparam int c_RB_OFS    = 0;
    localparam int c_RA_OFS    = 4;
    localparam int c_IFUN_OFS  = 8;
    localparam int c_ICODE_OFS = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Register specifiers must match how each instruction uses them (0xF = no register).
    function automatic logic instr_ok(input logic [3:0] ic, input logic [3:0] ra,
                                      input logic [3:0] rb);
        logic ok;
        ok = (ic <= c_I_POPQ);
        case (ic)
            c_I_RRMOV, c_I_OPQ:   ok = (ra != c_REG_NONE) && (rb != c_REG_NONE);
            c_I_IRMOV:            ok = (ra == c_REG_NONE) && (rb != c_REG_NONE);
            c_I_RMMOV, c_I_MRMOV: ok = (ra != c_REG_NONE);
            c_I_PUSHQ, c_I_POPQ:  ok = (ra != c_REG_NONE) && (rb == c_REG_NONE);
            default:              ok = ok;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
// Module   : imem_bank
// Brief    : Single-port instruction RAM, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module imem_bank #(
    parameter int ADDR_W = 9,
    parameter int IW     = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [IW-1:0]     i_wdata,
    output logic [IW-1:0]     o_rdata
);

    logic [IW-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Y86-style fetch stage: loadable instruction memory, PC, IDLE/RUN/
//            HALT FSM and registered instruction fields with valid/ready.
//            Define INSTR_CHECK_EN to add instr_err and halt on bad words.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int VALC_W = 16
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          wEn,
    input  logic [c_FIXED_W+VALC_W-1:0]   wDat,
    input  logic                          working,
    input  logic                          redirect,
    input  logic [ADDR_W-1:0]             redirect_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [3:0]                    icode,
    output logic [3:0]                    ifun,
    output logic [3:0]                    rA,
    output logic [3:0]                    rB,
    output logic [VALC_W-1:0]             valC,
    output logic [ADDR_W-1:0]             pc_out,
    output logic                          halted,
    output logic                          wr_err
`ifdef INSTR_CHECK_EN
    ,
    output logic                          instr_err
`endif
);

    localparam int IW          = c_FIXED_W + VALC_W;
    localparam int c_ICODE_LSB = VALC_W + c_ICODE_OFS;
    localparam int c_IFUN_LSB  = VALC_W + c_IFUN_OFS;
    localparam int c_RA_LSB    = VALC_W + c_RA_OFS;
    localparam int c_RB_LSB    = VALC_W + c_RB_OFS;

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_out;
    logic [IW-1:0]     r_word;
    logic              r_valid;
    logic              r_halted;
    logic              r_wr_err;

    logic [ADDR_W-1:0] w_mem_addr;
    logic [IW-1:0]     w_rdata;
    logic              w_mem_we;
    logic              w_accept;
    logic              w_fetch;
    logic              w_pc_start;
    logic              w_redir;
    logic              w_drop_valid;
    logic              w_set_halt;

`ifdef INSTR_CHECK_EN
    logic              r_bad;
    logic              r_instr_err;
    logic              w_set_ierr;
    logic              w_word_ok;
`endif

    // The single RAM port is shared: load address while idle, PC while working.
    assign w_mem_we   = wEn && !working;
    assign w_mem_addr = working ? r_pc : addr;

    imem_bank #(
        .ADDR_W (ADDR_W),
        .IW     (IW)
    ) u_imem (
        .clk     (clock),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (wDat),
        .o_rdata (w_rdata)
    );

    assign w_accept = r_valid && out_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch      = 1'b0;
        w_pc_start   = 1'b0;
        w_redir      = 1'b0;
        w_drop_valid = 1'b0;
        w_set_halt   = 1'b0;
`ifdef INSTR_CHECK_EN
        w_set_ierr   = 1'b0;
`endif
        if (!working) begin
            w_state_nxt  = ST_IDLE;
            w_drop_valid = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_pc_start  = 1'b1;
                end
                ST_RUN: begin
                    // Redirect squashes the presented word even under a stall.
                    if (redirect) begin
                        w_redir      = 1'b1;
                        w_drop_valid = 1'b1;
                    end else if (w_accept && icode == c_I_HALT) begin
                        w_state_nxt  = ST_HALT;
                        w_set_halt   = 1'b1;
                        w_drop_valid = 1'b1;
`ifdef INSTR_CHECK_EN
                    end else if (w_accept && r_bad) begin
                        w_state_nxt  = ST_HALT;
                        w_set_ierr   = 1'b1;
                        w_drop_valid = 1'b1;
`endif
                    end else if (!r_valid || out_ready) begin
                        w_fetch = 1'b1;
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_pc_out <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wEn && working;

            if (w_pc_start) begin
                r_pc <= addr;
            end else if (w_redir) begin
                r_pc <= redirect_pc;
            end else if (w_fetch) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_drop_valid) begin
                r_valid <= 1'b0;
            end else if (w_fetch) begin
                r_valid <= 1'b1;
            end

            if (w_fetch) begin
                r_word   <= w_rdata;
                r_pc_out <= r_pc;
            end

            if (!working) begin
                r_halted <= 1'b0;
            end else if (w_set_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifdef INSTR_CHECK_EN
    assign w_word_ok = instr_ok(w_rdata[c_ICODE_LSB +: 4], w_rdata[c_RA_LSB +: 4],
                                w_rdata[c_RB_LSB +: 4]);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_bad       <= 1'b0;
            r_instr_err <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_bad <= !w_word_ok;
            end
            if (!working) begin
                r_instr_err <= 1'b0;
            end else if (w_set_ierr) begin
                r_instr_err <= 1'b1;
            end
        end
    end

    assign instr_err = r_instr_err;
`endif

    assign out_valid = r_valid;
    assign icode     = r_word[c_ICODE_LSB +: 4];
    assign ifun      = r_word[c_IFUN_LSB +: 4];
    assign rA        = r_word[c_RA_LSB +: 4];
    assign rB        = r_word[c_RB_LSB +: 4];
    assign valC      = r_word[VALC_W-1:0];
    assign pc_out    = r_pc_out;
    assign halted    = r_halted;
    assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit (main instance ADDR_W=9, plus a
//            small ADDR_W=2 instance for PC wrap-around).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int ADDR_W = 9;
    localparam int VALC_W = 16;
    localparam int IW     = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [IW-1:0]     word;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              rst_n, wEn, working, redirect, out_ready;
    logic [ADDR_W-1:0] addr, redirect_pc, pc_out;
    logic [IW-1:0]     wDat;
    logic              out_valid, halted, wr_err;
    logic [3:0]        icode, ifun, rA, rB;
    logic [VALC_W-1:0] valC;
    logic [IW-1:0]     obs_word;
`ifdef INSTR_CHECK_EN
    logic              instr_err, s_instr_err;
`endif

    logic [1:0]        s_addr, s_pc_out;
    logic              s_wEn, s_working, s_out_valid, s_halted, s_wr_err;
    logic [IW-1:0]     s_wDat;
    logic [3:0]        s_icode, s_ifun, s_rA, s_rB;
    logic [VALC_W-1:0] s_valC;

    assign obs_word = {icode, ifun, rA, rB, valC};

    exp_t          sb[$];
    logic [IW-1:0] m_mem [0:(1<<ADDR_W)-1];
    int            checks = 0;
    int            errors = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .VALC_W(VALC_W)) u_dut (
        .clock(clock), .rst_n(rst_n), .addr(addr), .wEn(wEn), .wDat(wDat),
        .working(working), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .pc_out(pc_out), .halted(halted),
        .wr_err(wr_err)
`ifdef INSTR_CHECK_EN
        , .instr_err(instr_err)
`endif
    );

    fetch_unit #(.ADDR_W(2), .VALC_W(VALC_W)) u_dut_wrap (
        .clock(clock), .rst_n(rst_n), .addr(s_addr), .wEn(s_wEn), .wDat(s_wDat),
        .working(s_working), .redirect(1'b0), .redirect_pc(2'd0),
        .out_ready(1'b1), .out_valid(s_out_valid), .icode(s_icode), .ifun(s_ifun),
        .rA(s_rA), .rB(s_rB), .valC(s_valC), .pc_out(s_pc_out), .halted(s_halted),
        .wr_err(s_wr_err)
`ifdef INSTR_CHECK_EN
        , .instr_err(s_instr_err)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [IW-1:0] d);
        addr = a;
        wDat = d;
        wEn  = 1'b1;
        tick();
        wEn  = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic push_run(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({ADDR_W'(start + i), m_mem[start + i]});
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, halted, wr_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got v/h/e=%b expected 000", {out_valid, halted, wr_err});
        end
        checks++;
        if (pc_out !== '0) begin
            errors++;
            $display("FAIL reset_pc_out: got %h expected 0", pc_out);
        end
        checks++;
        if (obs_word !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", obs_word);
        end
    endtask

    task automatic test_load_run();
        write_word(0, 32'h10f50008);
        write_word(1, 32'h21450000);
        write_word(2, 32'h20120000);
        write_word(3, 32'h00000000);
        push_run(0, 4);
        addr = 0; out_ready = 1'b1; working = 1'b1;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            tick();
            if (out_valid && out_ready) begin
                exp_t e = sb.pop_front();
                checks++;
                if ({pc_out, obs_word} !== {e.pc, e.word}) begin
                    errors++;
                    $display("FAIL load_run: got pc=%h word=%h expected pc=%h word=%h",
                             pc_out, obs_word, e.pc, e.word);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL load_run_timeout: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
        checks++;
        if ({halted, out_valid, icode} !== {1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL halt_entry: got h=%b v=%b icode=%h expected h=1 v=0 icode=0",
                     halted, out_valid, icode);
        end
        working = 1'b0;
        tick();
        checks++;
        if ({halted, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL halt_exit: got h=%b v=%b expected 0 0", halted, out_valid);
        end
    endtask

    task automatic test_stall();
        bit stalled = 1'b0;
        push_run(0, 4);
        addr = 0; out_ready = 1'b1; working = 1'b1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            tick();
            if (!stalled && out_valid && pc_out == 1) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checks++;
                    if ({out_valid, pc_out, obs_word} !== {1'b1, ADDR_W'(1), 32'h21450000}) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b pc=%h word=%h expected v=1 pc=001 word=21450000",
                                 out_valid, pc_out, obs_word);
                    end
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                exp_t e = sb.pop_front();
                checks++;
                if ({pc_out, obs_word} !== {e.pc, e.word}) begin
                    errors++;
                    $display("FAIL stall_seq: got pc=%h word=%h expected pc=%h word=%h",
                             pc_out, obs_word, e.pc, e.word);
                end
            end
        end
        if (sb.size() != 0 || !stalled) begin
            checks++; errors++;
            $display("FAIL stall_timeout: %0d words outstanding, stalled=%b expected 0 and 1",
                     sb.size(), stalled);
            sb.delete();
        end
        tick();
        working = 1'b0;
        tick();
    endtask

    task automatic test_redirect();
        addr = 0; out_ready = 1'b1; working = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, pc_out} !== {1'b1, ADDR_W'(0)}) begin
            errors++;
            $display("FAIL redirect_pre: got v=%b pc=%h expected v=1 pc=000", out_valid, pc_out);
        end
        redirect = 1'b1; redirect_pc = 2;
        tick();
        redirect = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_squash: got v=%b expected 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, pc_out, icode, ifun} !== {1'b1, ADDR_W'(2), 4'h2, 4'h0}) begin
            errors++;
            $display("FAIL redirect_target: got v=%b pc=%h icode=%h ifun=%h expected v=1 pc=002 icode=2 ifun=0",
                     out_valid, pc_out, icode, ifun);
        end
        push_run(3, 1);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            tick();
            if (out_valid && out_ready) begin
                exp_t e = sb.pop_front();
                checks++;
                if ({pc_out, obs_word} !== {e.pc, e.word}) begin
                    errors++;
                    $display("FAIL redirect_seq: got pc=%h word=%h expected pc=%h word=%h",
                             pc_out, obs_word, e.pc, e.word);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL redirect_timeout: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL redirect_halt: got h=%b expected 1", halted);
        end
        working = 1'b0;
        tick();
    endtask

    task automatic test_wr_err();
        addr = 0; out_ready = 1'b0; working = 1'b1;
        tick();
        tick();
        wEn = 1'b1; addr = 1; wDat = 32'hffffffff;
        tick();
        wEn = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_pulse: got %b expected 1", wr_err);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_clear: got %b expected 0", wr_err);
        end
        working = 1'b0;
        tick();
        push_run(1, 3);
        addr = 1; out_ready = 1'b1; working = 1'b1;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            tick();
            if (out_valid && out_ready) begin
                exp_t e = sb.pop_front();
                checks++;
                if ({pc_out, obs_word} !== {e.pc, e.word}) begin
                    errors++;
                    $display("FAIL wr_drop_seq: got pc=%h word=%h expected pc=%h word=%h",
                             pc_out, obs_word, e.pc, e.word);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL wr_drop_timeout: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
        working = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [1:0] exp_pc [3];
        int idx = 0;
        exp_pc[0] = 2'd3; exp_pc[1] = 2'd0; exp_pc[2] = 2'd1;
        s_wEn = 1'b1;
        s_addr = 3; s_wDat = 32'h10f00000; tick();
        s_addr = 0; s_wDat = 32'h10f00000; tick();
        s_addr = 1; s_wDat = 32'h00000000; tick();
        s_wEn = 1'b0;
        s_addr = 3; s_working = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            tick();
            if (s_out_valid) begin
                checks++;
                if (s_pc_out !== exp_pc[idx]) begin
                    errors++;
                    $display("FAIL wrap_pc[%0d]: got %0d expected %0d", idx, s_pc_out, exp_pc[idx]);
                end
                idx++;
            end
        end
        if (idx != 3) begin
            checks++; errors++;
            $display("FAIL wrap_timeout: saw %0d words expected 3", idx);
        end
        tick();
        checks++;
        if ({s_halted, s_out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_halt: got h=%b v=%b expected 1 0", s_halted, s_out_valid);
        end
        s_working = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int bad_idle = 0;
        addr = 2; out_ready = 1'b0; working = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, pc_out} !== {1'b1, ADDR_W'(2)}) begin
            errors++;
            $display("FAIL areset_pre: got v=%b pc=%h expected v=1 pc=002", out_valid, pc_out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, halted, pc_out, obs_word} !== '0) begin
            errors++;
            $display("FAIL areset_clear: got v=%b h=%b pc=%h word=%h expected all 0",
                     out_valid, halted, pc_out, obs_word);
        end
        working = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_valid !== 1'b0) bad_idle++;
        end
        checks++;
        if (bad_idle != 0) begin
            errors++;
            $display("FAIL areset_idle: got %0d valid cycles expected 0", bad_idle);
        end
        push_run(0, 4);
        addr = 0; out_ready = 1'b1; working = 1'b1;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            tick();
            if (out_valid && out_ready) begin
                exp_t e = sb.pop_front();
                checks++;
                if ({pc_out, obs_word} !== {e.pc, e.word}) begin
                    errors++;
                    $display("FAIL areset_rerun: got pc=%h word=%h expected pc=%h word=%h",
                             pc_out, obs_word, e.pc, e.word);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL areset_timeout: %0d words outstanding, expected 0", sb.size());
            sb.delete();
        end
        tick();
        working = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wEn = 1'b0; working = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        addr = '0; redirect_pc = '0; wDat = '0;
        s_addr = '0; s_wEn = 1'b0; s_working = 1'b0; s_wDat = '0;
        tick();
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_load_run();
        test_stall();
        test_redirect();
        test_wr_err();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
